gates_selftest_ctrl: RTL and testbench
======================================

Name: gates_selftest_ctrl

Overview:
- Sequencer that exercises the two-input `gates` datapath as a built-in self-test.
- Drives `gates.iA` and `gates.iB` through all four input vectors in the order 00, 01, 10, 11 ({A,B}).
- Waits a programmable settle time per vector, then compares all five gate outputs against expected values.
- Reports per-vector and per-gate failure masks plus a pass flag; sits between system control logic and a `gates` instance.

Parameters:
- SETTLE_CYC, 2: cycles each vector is held before outputs are sampled. Legal range 1..15; 4-bit counter.

Ports:
- iClk  in  1  clock; all state changes on its rising edge
- iRstn  in  1  synchronous reset, active-low
- iStart  in  1  start request; sampled only in IDLE
- iAbort  in  1  abort a running test; sampled only in SETTLE/CHECK
- oA  out  1  drive to gates.iA
- oB  out  1  drive to gates.iB
- iAND  in  1  from gates.oAND
- iOR  in  1  from gates.oOR
- iNOT  in  1  from gates.oNOT
- iNAND  in  1  from gates.oNAND
- iNAND2  in  1  from gates.oNAND2
- oBusy  out  1  high in SETTLE and CHECK
- oDone  out  1  one-cycle pulse at test completion
- oPass  out  1  high when the last completed test had no mismatch
- oFailVec  out  4  bit i set if vector i ({A,B}=i) had any mismatch
- oFailGate  out  5  accumulated mismatching gates: [0]AND [1]OR [2]NOT [3]NAND [4]NAND2

Behaviour:
- All outputs are registered.
- Reset (iRstn=0 at an edge, any state, including mid-test):
  - Next state IDLE.
  - oA=oB=0, oBusy=0, oDone=0, oPass=0, oFailVec=0, oFailGate=0.
  - Vector index=0, settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - If iStart=1 at an edge, go to SETTLE.
  - On entry to SETTLE: idx=0, oA=0, oB=0, cnt=0, oBusy=1; oFailVec, oFailGate and oPass cleared.
  - Otherwise remain in IDLE; results hold.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1, go to CHECK. Dwell is exactly SETTLE_CYC cycles.
- CHECK (1 cycle): sample the gate inputs and compare against:
  - expected AND = A&B, OR = A|B, NOT = ~A, NAND = NAND2 = ~(A&B), where A=oA, B=oB.
  - For each mismatching gate g, set oFailGate[g]. If any mismatch, set oFailVec[idx].
- CHECK exit:
  - If idx<3: idx++, oA/oB take the new idx bits at the same edge, cnt=0, go to SETTLE.
  - If idx==3: go to DONE, oBusy=0, oA=oB=0.
- DONE (1 cycle):
  - oDone=1; oPass=1 if oFailVec==0 (the update includes the final CHECK). Go to IDLE.
  - oPass, oFailVec and oFailGate hold until the next accepted iStart or reset.
- Latency, iStart edge to oDone high: 4*(SETTLE_CYC+1) cycles of oBusy, then oDone in the next cycle. SETTLE_CYC=2 gives 12 busy cycles; oDone is asserted during cycle 13.
- iStart while busy or in DONE: ignored, no queuing.
- iAbort=1 in SETTLE or CHECK:
  - Next state IDLE; oBusy=0, oA=oB=0, oPass=0.
  - No oDone pulse; partial oFailVec/oFailGate retained.
  - The abort takes priority over that cycle's CHECK update.
- iAbort in IDLE or DONE: ignored.
- Simultaneous iAbort and reset: reset wins.
- Inputs from gates are assumed combinationally valid within SETTLE_CYC cycles; no internal synchronizer.

Test Plan:
- Golden run: real `gates` instance, SETTLE_CYC=2, pulse iStart → oA/oB step 00,01,10,11, each held 3 cycles; oBusy high 12 cycles; oDone single pulse; oPass=1, oFailVec=0000, oFailGate=00000.
- Fault injection: replace iNAND2 with constant 1 → mismatch only at vector 11; oPass=0, oFailVec=1000, oFailGate=10000.
- Multi-fault: iNOT tied to iA (inverted sense) → oFailVec=1111, oFailGate=00100; then rerun with correct wiring → fields cleared at start, oPass=1.
- Abort/ignore: iStart pulsed again during busy → no effect; iAbort asserted in vector 10 SETTLE → next cycle oBusy=0, oA=oB=0, no oDone, oPass=0.
- Reset mid-test: iRstn=0 for 1 cycle during vector 01 CHECK → all outputs 0 next cycle, state IDLE; a new iStart then completes with the normal 12-cycle timing.
- Parameter sweep: SETTLE_CYC=1 and 15 → busy length 8 and 64 cycles respectively; results identical to the golden run.

Source files
------------

// File: rtl/gates_selftest_ctrl.sv
// Built-in self-test sequencer for the two-input gates datapath: walks {A,B}
// through 00..11, lets each vector settle, and accumulates per-vector/per-gate misses.

module gates_selftest_lane (
  input  logic got,
  input  logic want,
  output logic miss
);
  assign miss = got ^ want;
endmodule

module gates_selftest_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic       iStart,
  input  logic       iAbort,
  output logic       oA,
  output logic       oB,
  input  logic       iAND,
  input  logic       iOR,
  input  logic       iNOT,
  input  logic       iNAND,
  input  logic       iNAND2,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oFailVec,
  output logic [4:0] oFailGate
);
  localparam int NUM_GATES = 5;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0] state;
  logic [1:0] idx;
  logic [1:0] nxtIdx;
  logic [3:0] cnt;
  logic [NUM_GATES-1:0] gotGate, wantGate, missGate;
  logic [3:0] failVecNxt;

  // Bit order matches oFailGate: AND, OR, NOT, NAND, NAND2
  assign gotGate  = {iNAND2, iNAND, iNOT, iOR, iAND};
  assign wantGate = {~(oA & oB), ~(oA & oB), ~oA, oA | oB, oA & oB};

  genvar g;
  generate
    for (g = 0; g < NUM_GATES; g++) begin : gLane
      gates_selftest_lane uLane (.got(gotGate[g]), .want(wantGate[g]), .miss(missGate[g]));
    end
  endgenerate

  assign nxtIdx     = idx + 2'd1;
  assign failVecNxt = oFailVec | ((|missGate) ? (4'b0001 << idx) : 4'b0000);

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      oA        <= 1'b0;
      oB        <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oPass     <= 1'b0;
      oFailVec  <= '0;
      oFailGate <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          state     <= SETTLE;
          idx       <= '0;
          cnt       <= '0;
          oA        <= 1'b0;
          oB        <= 1'b0;
          oBusy     <= 1'b1;
          oPass     <= 1'b0;
          oFailVec  <= '0;
          oFailGate <= '0;
        end
        SETTLE: if (iAbort) begin
          state <= IDLE;
          oBusy <= 1'b0;
          oA    <= 1'b0;
          oB    <= 1'b0;
          oPass <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= CHECK;
        end
        CHECK: if (iAbort) begin
          // Abort wins over this cycle's compare: partial results stay as they were
          state <= IDLE;
          oBusy <= 1'b0;
          oA    <= 1'b0;
          oB    <= 1'b0;
          oPass <= 1'b0;
        end else begin
          oFailGate <= oFailGate | missGate;
          oFailVec  <= failVecNxt;
          if (idx != 2'd3) begin
            idx   <= nxtIdx;
            oA    <= nxtIdx[1];
            oB    <= nxtIdx[0];
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            state <= DONE;
            oBusy <= 1'b0;
            oA    <= 1'b0;
            oB    <= 1'b0;
            oDone <= 1'b1;
            oPass <= (failVecNxt == 4'b0000);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gates_selftest_ctrl.sv
// Bench for gates_selftest_ctrl: three instances (SETTLE_CYC 2/1/15) driven by a
// behavioural gates model with selectable faults; results checked via a scoreboard.

module tb_gates_selftest_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b0;
  logic [2:0] start = '0;
  logic       abort = 1'b0;
  int         faultMode = 0;   // 0 none, 1 NAND2 stuck 1, 2 NOT wired to A
  int         vectors = 0;
  int         miscompares = 0;

  logic       aW[3], bW[3], busyW[3], doneW[3], passW[3];
  logic [3:0] fvW[3];
  logic [4:0] fgW[3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gDut
      localparam int SC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic nAnd, nOr, nNot, nNand, nNand2;
      assign nAnd   = aW[g] & bW[g];
      assign nOr    = aW[g] | bW[g];
      assign nNot   = (faultMode == 2) ? aW[g] : ~aW[g];
      assign nNand  = ~(aW[g] & bW[g]);
      assign nNand2 = (faultMode == 1) ? 1'b1 : ~(aW[g] & bW[g]);
      gates_selftest_ctrl #(.SETTLE_CYC(SC)) dut (
        .iClk(clk), .iRstn(rstn), .iStart(start[g]), .iAbort(abort),
        .oA(aW[g]), .oB(bW[g]),
        .iAND(nAnd), .iOR(nOr), .iNOT(nNot), .iNAND(nNand), .iNAND2(nNand2),
        .oBusy(busyW[g]), .oDone(doneW[g]), .oPass(passW[g]),
        .oFailVec(fvW[g]), .oFailGate(fgW[g])
      );
    end
  endgenerate

  typedef struct {
    logic       pass;
    logic [3:0] fv;
    logic [4:0] fg;
    int         busy;
  } exp_t;
  exp_t sbq[$];

  function automatic int scOf(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  function automatic exp_t model(int d, int fm);
    exp_t e;
    e.fv = '0;
    e.fg = '0;
    for (int v = 0; v < 4; v++) begin
      logic a, b;
      logic [4:0] want, got;
      a = 1'((v >> 1) & 1);
      b = 1'(v & 1);
      want = {~(a & b), ~(a & b), ~a, a | b, a & b};
      got = want;
      if (fm == 1) got[4] = 1'b1;
      if (fm == 2) got[2] = a;
      e.fg = e.fg | (got ^ want);
      if (got != want) e.fv = e.fv | (4'b0001 << v);
    end
    e.pass = (e.fv == 4'b0000);
    e.busy = 4 * (scOf(d) + 1);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chkIdle(int d, string tag);
    chk({tag, ".ab"},   {aW[d], bW[d]}, 0);
    chk({tag, ".busy"}, busyW[d], 0);
    chk({tag, ".done"}, doneW[d], 0);
    chk({tag, ".pass"}, passW[d], 0);
    chk({tag, ".fv"},   fvW[d], 0);
    chk({tag, ".fg"},   fgW[d], 0);
  endtask

  // Full run; restartAt >= 0 re-pulses iStart at that busy cycle (must be ignored)
  task automatic runTest(int d, int restartAt);
    exp_t e;
    int busy, cyc;
    sbq.push_back(model(d, faultMode));
    @(negedge clk) start[d] = 1'b1;
    @(negedge clk) start[d] = 1'b0;
    busy = 0;
    cyc = 0;
    while (doneW[d] !== 1'b1 && cyc < 300) begin
      if (busyW[d] === 1'b1) begin
        chk("vecAB", {aW[d], bW[d]}, busy / (scOf(d) + 1));
        busy++;
      end
      start[d] = (busy == restartAt);
      cyc++;
      @(negedge clk);
    end
    chk("doneSeen", doneW[d], 1);
    e = sbq.pop_front();
    chk("busyLen",  busy, e.busy);
    chk("doneBusy", busyW[d], 0);
    chk("pass",     passW[d], e.pass);
    chk("failVec",  fvW[d], e.fv);
    chk("failGate", fgW[d], e.fg);
    start[d] = 1'b1;   // start during DONE is dropped
    @(negedge clk) start[d] = 1'b0;
    chk("donePulse", doneW[d], 0);
    chk("noRestart", busyW[d], 0);
    chk("passHold",  passW[d], e.pass);
    @(negedge clk);
  endtask

  task automatic startAdvance(int d, int n);
    @(negedge clk) start[d] = 1'b1;
    @(negedge clk) start[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int doneCnt;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chkIdle(d, "reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chkIdle(0, "idle");

    runTest(0, 5);          // golden, with an ignored mid-run start
    faultMode = 1;
    runTest(0, -1);
    faultMode = 2;
    runTest(0, -1);
    faultMode = 0;
    runTest(0, -1);         // clean rerun clears previous failures

    // Abort during vector 10 settle, NOT fault active: vectors 00/01 already failed
    faultMode = 2;
    startAdvance(0, 6);
    chk("abortPre.ab",   {aW[0], bW[0]}, 2'b10);
    chk("abortPre.busy", busyW[0], 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort.ab",   {aW[0], bW[0]}, 0);
    chk("abort.busy", busyW[0], 0);
    chk("abort.pass", passW[0], 0);
    chk("abort.fv",   fvW[0], 4'b0011);
    chk("abort.fg",   fgW[0], 5'b00100);
    doneCnt = 0;
    repeat (20) begin
      if (doneW[0] === 1'b1) doneCnt++;
      @(negedge clk);
    end
    chk("abort.noDone", doneCnt, 0);
    faultMode = 0;

    // Reset during vector 01 check, then a normal run
    startAdvance(0, 5);
    chk("rstPre.ab", {aW[0], bW[0]}, 2'b01);
    rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    chkIdle(0, "midRst");
    runTest(0, -1);

    runTest(1, -1);
    runTest(2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
